fpga_robots_game_tm_scan: RTL and testbench
===========================================

Name: fpga_robots_game_tm_scan

Overview:
- Command-driven sequencer that owns the external port of the video block's 8 kB tile map: tm_adr, tm_wrt, tm_wen and tm_red.
- Sits directly upstream of the video generator and gives game logic three bulk operations over the play area:
  - clear the board;
  - count robot and player cells;
  - clear the per-byte work bits.
- Status columns are never touched. Accesses can optionally be confined to the vertical blanking interval.

Parameters:
VBI_ONLY  0  1 = issue tile map accesses only while vbi is high; 0 = issue every cycle
ROWS  48  tile map byte rows scanned (each byte = two vertically stacked cells)
COLS  120  play-area byte columns per row (columns 120-127 are the status area, never accessed)

Ports:
clk  in  1  system clock, ~65 MHz, rising edge
rst  in  1  synchronous reset, active-low
cmd_valid  in  1  command request
cmd_op  in  2  0=CLEAR, 1=COUNT, 2=TAGCLR, 3=NOP
cmd_ready  out  1  high only in IDLE
done  out  1  one-cycle pulse when a command completes
n_robot  out  14  robot cells counted by last COUNT
n_player  out  14  player cells counted by last COUNT
vbi  in  1  vertical blanking indication from video block
tm_adr  out  13  tile map address, registered
tm_wrt  out  8  tile map write data, registered
tm_wen  out  1  tile map write enable, registered
tm_red  in  8  tile map read data, valid one clock after tm_adr

Behaviour:
- Address generation:
  - Byte address = {row[5:0], col[6:0]}, with row 0..ROWS-1 and col 0..COLS-1.
  - col increments each access and wraps 119→0 with row+1.
  - Last address is 47*128+119 = 6135.
- Play byte layout:
  - [1:0] = upper cell, [3:2] = lower cell; codes 0 blank, 1 robot, 2 trash, 3 player.
  - [7:4] = work bits.
- Reset (rst low at a clock edge), also when asserted mid-command:
  - State goes to IDLE; any command in progress is abandoned and no further writes are issued.
  - cmd_ready=1, done=0, n_robot=0, n_player=0, tm_adr=0, tm_wrt=0, tm_wen=0.
- Handshake:
  - A command is accepted on a clock edge with cmd_valid && cmd_ready.
  - cmd_ready drops the next cycle and stays low until the cycle after done.
  - cmd_valid is ignored while busy.
- Gate: "go" = (VBI_ONLY==0) || vbi. When go is low:
  - no new address is issued and tm_wen=0;
  - the position counter holds;
  - a read already issued is still captured the next cycle.
- States: IDLE, CLEAR, COUNT, DRAIN, TAG_RD, TAG_WR, FINISH.
- IDLE: on accept, row/col clear to 0.
  - op0 → CLEAR.
  - op1 → COUNT; n_robot and n_player clear to 0 at accept.
  - op2 → TAG_RD.
  - op3 → FINISH.
- CLEAR: each go cycle drives tm_adr=current, tm_wrt=0, tm_wen=1 and advances. After the write to the last address → FINISH.
- COUNT:
  - Each go cycle drives tm_adr=current with tm_wen=0 and sets a read-pending flag.
  - The cycle after a read, tm_red is decoded:
    - n_robot += (tm_red[1:0]==1) + (tm_red[3:2]==1);
    - n_player += (tm_red[1:0]==3) + (tm_red[3:2]==3).
  - After issuing the last address → DRAIN (one cycle, absorbs the final read) → FINISH.
  - Counters are 14 bits and cannot overflow (maximum 11520).
- TAG_RD: on a go cycle, issue a read of the current address → TAG_WR.
- TAG_WR:
  - Latch tm_red once, in the cycle after the read.
  - On a go cycle (which may be the same cycle), write {4'd0, latched[3:0]} to the same address with tm_wen=1 and advance.
  - Next state: TAG_RD, or FINISH if that was the last address.
  - Unpaused cost is 2 cycles per byte.
- FINISH: tm_wen=0, done=1 for one cycle → IDLE.
- Outputs:
  - n_robot and n_player hold their values until the next COUNT accept or reset.
  - tm_wen is never high outside CLEAR and TAG_WR.
- Unpaused latency, accept at edge k:
  - CLEAR: writes at cycles k+1..k+5760, done at k+5761.
  - COUNT: done at k+5762.
  - TAGCLR: done at k+11521.
  - NOP: done at k+1.

Test Plan:
- Preload all 8192 bytes 0xFF, CLEAR → exactly 5760 tm_wen cycles:
  - addresses 0..119, 128..247, …, 6016..6135, in order;
  - bytes at columns 120-127 stay 0xFF;
  - done at accept+5761; cmd_ready=1 the next cycle.
- Preload play area 0x00; set byte 0=0x05, byte 130=0x0D, byte 6135=0xCF. COUNT → n_robot=3, n_player=3, zero writes, done at accept+5762.
- Play area all 0xA7. TAGCLR → every play byte reads 0x07, status bytes unchanged, done at accept+11521.
- VBI_ONLY=1 with vbi toggling 100 high / 200 low:
  - no tm_adr change and no tm_wen while vbi is low;
  - CLEAR result identical to test 1; total writes 5760.
- Reset low at cycle 1000 of CLEAR:
  - next cycle tm_wen=0, cmd_ready=1, counts 0;
  - bytes at address ≥ the reset point are unmodified;
  - a new COUNT then runs correctly.
- cmd_valid held high with ops alternating during busy → only the first op is executed. NOP → done at accept+1 with no tile map access.

Source files
------------

// File: rtl/fpga_robots_game_tm_scan_if.sv
// Command handshake between game logic and the tile map scan sequencer.
interface fpga_robots_game_tm_scan_if;
  localparam int unsigned OP_W  = 2;
  localparam int unsigned CNT_W = 14;

  logic             cmd_valid;
  logic [OP_W-1:0]  cmd_op;
  logic             cmd_ready;
  logic             done;
  logic [CNT_W-1:0] n_robot;
  logic [CNT_W-1:0] n_player;

  // Game logic side issues commands and reads results
  modport master (
    output cmd_valid, cmd_op,
    input  cmd_ready, done, n_robot, n_player
  );

  // Sequencer side accepts commands and reports results
  modport slave (
    input  cmd_valid, cmd_op,
    output cmd_ready, done, n_robot, n_player
  );
endinterface

// File: rtl/fpga_robots_game_tm_scan.sv
// Tile map scan sequencer: bulk clear, robot/player count and work-bit clear
// over the play area of the video tile map. Status columns are never accessed.
module fpga_robots_game_tm_scan #(
  parameter int unsigned VBI_ONLY = 0,
  parameter int unsigned ROWS     = 48,
  parameter int unsigned COLS     = 120
) (
  input  logic                              clk,
  input  logic                              rst,
  fpga_robots_game_tm_scan_if.slave         cmd,
  input  logic                              vbi,
  output logic [12:0]                       tm_adr,
  output logic [7:0]                        tm_wrt,
  output logic                              tm_wen,
  input  logic [7:0]                        tm_red
);

  localparam int unsigned ROW_W = 6;
  localparam int unsigned COL_W = 7;
  localparam int unsigned DAT_W = 8;
  localparam int unsigned CNT_W = 14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COUNT,
    S_DRAIN,
    S_TAG_RD,
    S_TAG_WR,
    S_FINISH
  } state_t;

  state_t             state;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic               rd_pend;
  logic               tag_held;
  logic [DAT_W-1:0]   tag_byte;

  logic               go_c;
  logic               last_c;
  logic               accept_c;
  logic [ROW_W-1:0]   nxt_row_c;
  logic [COL_W-1:0]   nxt_col_c;
  logic [1:0]         robot_inc_c;
  logic [1:0]         player_inc_c;
  logic [DAT_W-1:0]   tag_src_c;

  // Access gate, end-of-area detect and handshake
  assign go_c     = (VBI_ONLY == 0) || vbi;
  assign last_c   = (row == ROW_W'(ROWS - 1)) && (col == COL_W'(COLS - 1));
  assign accept_c = cmd.cmd_valid && cmd.cmd_ready;

  // Next play-area position: column wraps at the status area boundary
  always_comb begin
    nxt_row_c = row;
    nxt_col_c = col + COL_W'(1);
    if (col == COL_W'(COLS - 1)) begin
      nxt_row_c = row + ROW_W'(1);
      nxt_col_c = '0;
    end
  end

  // Per-byte cell decode for counting; each byte holds two stacked cells
  always_comb begin
    robot_inc_c  = 2'(tm_red[1:0] == 2'd1) + 2'(tm_red[3:2] == 2'd1);
    player_inc_c = 2'(tm_red[1:0] == 2'd3) + 2'(tm_red[3:2] == 2'd3);
  end

  // Read data for the work-bit clear: live bus on the first cycle, latch after a stall
  assign tag_src_c = tag_held ? tag_byte : tm_red;

  // Sequencer state, position counter and registered tile map / result outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      row           <= '0;
      col           <= '0;
      rd_pend       <= 1'b0;
      tag_held      <= 1'b0;
      tag_byte      <= '0;
      cmd.cmd_ready <= 1'b1;
      cmd.done      <= 1'b0;
      cmd.n_robot   <= '0;
      cmd.n_player  <= '0;
      tm_adr        <= '0;
      tm_wrt        <= '0;
      tm_wen        <= 1'b0;
    end else begin
      cmd.done <= 1'b0;
      tm_wen   <= 1'b0;
      rd_pend  <= 1'b0;

      if (rd_pend) begin
        cmd.n_robot  <= cmd.n_robot + CNT_W'(robot_inc_c);
        cmd.n_player <= cmd.n_player + CNT_W'(player_inc_c);
      end

      case (state)
        S_IDLE: begin
          cmd.cmd_ready <= 1'b1;
          if (accept_c) begin
            cmd.cmd_ready <= 1'b0;
            row           <= '0;
            col           <= '0;
            case (cmd.cmd_op)
              2'd0: state <= S_CLEAR;
              2'd1: begin
                state        <= S_COUNT;
                cmd.n_robot  <= '0;
                cmd.n_player <= '0;
              end
              2'd2:    state <= S_TAG_RD;
              default: state <= S_FINISH;
            endcase
          end
        end

        S_CLEAR: begin
          if (go_c) begin
            tm_adr <= {row, col};
            tm_wrt <= '0;
            tm_wen <= 1'b1;
            row    <= nxt_row_c;
            col    <= nxt_col_c;
            if (last_c) state <= S_FINISH;
          end
        end

        S_COUNT: begin
          if (go_c) begin
            tm_adr  <= {row, col};
            rd_pend <= 1'b1;
            row     <= nxt_row_c;
            col     <= nxt_col_c;
            if (last_c) state <= S_DRAIN;
          end
        end

        S_DRAIN: state <= S_FINISH;

        S_TAG_RD: begin
          tag_held <= 1'b0;
          if (go_c) begin
            tm_adr <= {row, col};
            state  <= S_TAG_WR;
          end
        end

        S_TAG_WR: begin
          if (!tag_held) begin
            tag_held <= 1'b1;
            tag_byte <= tm_red;
          end
          if (go_c) begin
            tm_adr <= {row, col};
            tm_wrt <= tag_src_c & 8'h0F;
            tm_wen <= 1'b1;
            row    <= nxt_row_c;
            col    <= nxt_col_c;
            state  <= last_c ? S_FINISH : S_TAG_RD;
          end
        end

        S_FINISH: begin
          cmd.done <= 1'b1;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_robots_game_tm_scan.sv
// Bench for the tile map scan sequencer: instance 0 ungated, instance 1 gated by vbi.
module tb_fpga_robots_game_tm_scan;

  localparam int MEM_N = 8192;

  typedef struct packed {
    int cyc;
    int r;
    int p;
    int w;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]        rst_b;
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic              vbi1 = 1'b0;
  logic [1:0][12:0]  tm_adr;
  logic [1:0][7:0]   tm_wrt;
  logic [1:0]        tm_wen;
  logic [1:0][7:0]   tm_red;
  logic [1:0]        done_w;
  logic [1:0]        ready_w;
  logic [1:0][13:0]  nr_w;
  logic [1:0][13:0]  np_w;
  logic [7:0]        mem [2][MEM_N];

  exp_t              sb_q [2][$];
  int                wtot [2];
  int                oerr [2];
  logic [12:0]       exp_wadr [2];
  logic [1:0]        chk_rdy = 2'b00;
  int                gerr = 0;
  logic [12:0]       adr_last = '0;
  int                ph = 0;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    fpga_robots_game_tm_scan_if cif ();
    assign cif.cmd_valid = cmd_valid;
    assign cif.cmd_op    = cmd_op;
    assign done_w[d]     = cif.done;
    assign ready_w[d]    = cif.cmd_ready;
    assign nr_w[d]       = cif.n_robot;
    assign np_w[d]       = cif.n_player;
    assign tm_red[d]     = mem[d][tm_adr[d]];

    fpga_robots_game_tm_scan #(
      .VBI_ONLY (d),
      .ROWS     (48),
      .COLS     (120)
    ) u_dut (
      .clk    (clk),
      .rst    (rst_b[d]),
      .cmd    (cif.slave),
      .vbi    ((d == 0) ? 1'b0 : vbi1),
      .tm_adr (tm_adr[d]),
      .tm_wrt (tm_wrt[d]),
      .tm_wen (tm_wen[d]),
      .tm_red (tm_red[d])
    );
  end

  // Tile map model: write on the clock, read follows the registered address
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      if (tm_wen[d]) mem[d][tm_adr[d]] = tm_wrt[d];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [12:0] next_adr(input logic [12:0] a);
    logic [6:0] c;
    logic [5:0] r;
    c = a[6:0];
    r = a[12:7];
    if (c == 7'd119) return {6'(r + 6'd1), 7'd0};
    return {r, 7'(c + 7'd1)};
  endfunction

  // Monitor: write order, scoreboard pop on done, vbi gate on instance 1
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (tm_wen[d]) begin
        wtot[d]++;
        if (tm_adr[d] !== exp_wadr[d]) oerr[d]++;
        exp_wadr[d] = next_adr(exp_wadr[d]);
      end
      if (chk_rdy[d]) chk($sformatf("ready_after_done%0d", d), 32'(ready_w[d]), 1);
      chk_rdy[d] = done_w[d];
      if (done_w[d]) begin
        chk($sformatf("done_expected%0d", d), (sb_q[d].size() > 0) ? 1 : 0, 1);
        if (sb_q[d].size() > 0) begin
          exp_t e;
          e = sb_q[d].pop_front();
          if (e.cyc >= 0) chk($sformatf("done_cycle%0d", d), cyc, e.cyc);
          chk($sformatf("n_robot%0d", d), 32'(nr_w[d]), e.r);
          chk($sformatf("n_player%0d", d), 32'(np_w[d]), e.p);
          chk($sformatf("writes%0d", d), wtot[d], e.w);
          chk($sformatf("write_order_errs%0d", d), oerr[d], 0);
          chk($sformatf("ready_low_at_done%0d", d), 32'(ready_w[d]), 0);
        end
        wtot[d]     = 0;
        oerr[d]     = 0;
        exp_wadr[d] = '0;
      end
    end
    if (!vbi1 && (tm_wen[1] || tm_adr[1] != adr_last)) gerr++;
    adr_last = tm_adr[1];
    ph   = (ph == 299) ? 0 : ph + 1;
    vbi1 = (ph < 100);
  end

  task automatic fill(input int d, input logic [7:0] pv, input logic [7:0] sv);
    for (int a = 0; a < MEM_N; a++)
      mem[d][a] = ((a < 48 * 128) && ((a % 128) < 120)) ? pv : sv;
  endtask

  task automatic mem_check(input string name, input int d, input int kind);
    int bad;
    logic [7:0] ex;
    bit play;
    bad = 0;
    for (int a = 0; a < MEM_N; a++) begin
      play = (a < 48 * 128) && ((a % 128) < 120);
      case (kind)
        1:       ex = play ? 8'h00 : 8'hFF;
        2:       ex = play ? 8'h07 : 8'hA7;
        default: ex = (play && a <= 1063) ? 8'h00 : 8'hFF;
      endcase
      if (mem[d][a] !== ex) bad++;
    end
    chk(name, bad, 0);
  endtask

  task automatic wait_ready(input int d);
    for (int i = 0; i < 20; i++) begin
      if (ready_w[d]) break;
      @(negedge clk);
    end
    chk($sformatf("ready_before_cmd%0d", d), 32'(ready_w[d]), 1);
  endtask

  task automatic issue(input int d, input logic [1:0] op, input bit push, input int lat,
                       input int r, input int p, input int w, output int n);
    exp_t e;
    wait_ready(d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(negedge clk);
    n = cyc;
    cmd_valid = 1'b0;
    if (push) begin
      e.cyc = (lat < 0) ? -1 : n + lat;
      e.r   = r;
      e.p   = p;
      e.w   = w;
      sb_q[d].push_back(e);
    end
  endtask

  task automatic wait_done(input int d, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb_q[d].size() == 0) break;
      @(negedge clk);
    end
    chk($sformatf("cmd_finished%0d", d), sb_q[d].size(), 0);
    sb_q[d].delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_b     = 2'b00;
    cmd_valid = 1'b0;
    cmd_op    = 2'd3;
    repeat (3) @(negedge clk);
    chk("rst_tm_wen", 32'(tm_wen[0]), 0);
    chk("rst_cmd_ready", 32'(ready_w[0]), 1);
    chk("rst_done", 32'(done_w[0]), 0);
    chk("rst_n_robot", 32'(nr_w[0]), 0);
    chk("rst_n_player", 32'(np_w[0]), 0);
    chk("rst_tm_adr", 32'(tm_adr[0]), 0);
    rst_b[0] = 1'b1;
    @(negedge clk);

    // CLEAR over a fully 0xFF map
    fill(0, 8'hFF, 8'hFF);
    issue(0, 2'd0, 1'b1, 5761, 0, 0, 5760, n);
    wait_done(0, 6000);
    mem_check("clear_mem", 0, 1);

    // COUNT with three populated bytes; status bytes hold robots that must be ignored
    fill(0, 8'h00, 8'h05);
    mem[0][0]    = 8'h05;
    mem[0][130]  = 8'h0D;
    mem[0][6135] = 8'hCF;
    issue(0, 2'd1, 1'b1, 5762, 3, 3, 0, n);
    wait_done(0, 6000);

    // TAGCLR strips work bits; counts hold from the last COUNT
    fill(0, 8'hA7, 8'hA7);
    issue(0, 2'd2, 1'b1, 11521, 3, 3, 5760, n);
    wait_done(0, 12000);
    mem_check("tagclr_mem", 0, 2);

    // Reset in the middle of a CLEAR
    fill(0, 8'hFF, 8'hFF);
    issue(0, 2'd0, 1'b0, 0, 0, 0, 0, n);
    repeat (1000) @(negedge clk);
    chk("pre_rst_tm_adr", 32'(tm_adr[0]), 1063);
    chk("pre_rst_tm_wen", 32'(tm_wen[0]), 1);
    rst_b[0] = 1'b0;
    @(negedge clk);
    chk("mid_rst_tm_wen", 32'(tm_wen[0]), 0);
    chk("mid_rst_cmd_ready", 32'(ready_w[0]), 1);
    chk("mid_rst_n_robot", 32'(nr_w[0]), 0);
    chk("mid_rst_n_player", 32'(np_w[0]), 0);
    chk("mid_rst_tm_adr", 32'(tm_adr[0]), 0);
    rst_b[0]    = 1'b1;
    wtot[0]     = 0;
    oerr[0]     = 0;
    exp_wadr[0] = '0;
    repeat (5) @(negedge clk);
    mem_check("mid_rst_mem", 0, 3);
    issue(0, 2'd1, 1'b1, 5762, 0, 9520, 0, n);
    wait_done(0, 6000);

    // cmd_valid held with other ops while busy: only the first COUNT runs
    wait_ready(0);
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    @(negedge clk);
    n = cyc;
    begin
      exp_t e;
      e.cyc = n + 5762;
      e.r   = 0;
      e.p   = 9520;
      e.w   = 0;
      sb_q[0].push_back(e);
    end
    for (int i = 0; i < 6000 && sb_q[0].size() != 0; i++) begin
      cmd_op = (cmd_op == 2'd0) ? 2'd2 : 2'd0;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("hold_cmd_finished", sb_q[0].size(), 0);
    sb_q[0].delete();
    repeat (4) @(negedge clk);
    mem_check("hold_mem", 0, 3);

    // NOP: immediate done, no tile map access
    issue(0, 2'd3, 1'b1, 1, 0, 9520, 0, n);
    wait_done(0, 10);
    chk("nop_tm_adr", 32'(tm_adr[0]), 6135);

    // Gated CLEAR on the vbi-only instance
    rst_b[0] = 1'b0;
    fill(1, 8'hFF, 8'hFF);
    rst_b[1] = 1'b1;
    @(negedge clk);
    issue(1, 2'd0, 1'b1, -1, 0, 0, 5760, n);
    wait_done(1, 20000);
    mem_check("vbi_clear_mem", 1, 1);
    chk("vbi_gate_violations", gerr, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
